// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - six-step instruction sequencer and control decode
// Drives every datapath bus-enable and latch strobe from (step, ir, flags).
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       flag_c,
  input  logic       flag_a,
  input  logic       flag_e,
  input  logic       flag_z,
  output logic [2:0] step,
  output logic [3:0] r_en,
  output logic [3:0] r_set,
  output logic       iar_en,
  output logic       iar_set,
  output logic       ir_set,
  output logic       mar_set,
  output logic       ram_en,
  output logic       ram_set,
  output logic       tmp_set,
  output logic       b1,
  output logic       acc_en,
  output logic       acc_set,
  output logic       flag_set,
  output logic [2:0] op,
  output logic       carry_in
);

  typedef enum logic [2:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } step_t;

  step_t      r_step;
  step_t      w_step_nxt;
  logic [1:0] w_ra;
  logic [1:0] w_rb;
  logic       w_jump;

  assign w_ra   = ir[3:2];
  assign w_rb   = ir[1:0];
  assign w_jump = (ir[3] & flag_c) | (ir[2] & flag_a) | (ir[1] & flag_e) | (ir[0] & flag_z);
  assign step   = r_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_step <= S1;
    else      r_step <= w_step_nxt;
  end

  always_comb begin
    w_step_nxt = S1;
    r_en       = 4'b0000;
    r_set      = 4'b0000;
    iar_en     = 1'b0;
    iar_set    = 1'b0;
    ir_set     = 1'b0;
    mar_set    = 1'b0;
    ram_en     = 1'b0;
    ram_set    = 1'b0;
    tmp_set    = 1'b0;
    b1         = 1'b0;
    acc_en     = 1'b0;
    acc_set    = 1'b0;
    flag_set   = 1'b0;
    op         = 3'b000;
    carry_in   = 1'b0;

    case (r_step)
      S1:      w_step_nxt = S2;
      S2:      w_step_nxt = S3;
      S3:      w_step_nxt = S4;
      S4:      w_step_nxt = S5;
      S5:      w_step_nxt = S6;
      default: w_step_nxt = S1;
    endcase

    case (r_step)
      // Fetch: MAR <= IAR, ACC <= IAR+1, IR <= RAM[MAR], IAR <= ACC.
      S1: begin iar_en = 1'b1; b1 = 1'b1; mar_set = 1'b1; acc_set = 1'b1; end
      S2: begin ram_en = 1'b1; ir_set = 1'b1; end
      S3: begin acc_en = 1'b1; iar_set = 1'b1; end
      default: begin
        if (ir[7]) begin
          case (r_step)
            S4: begin r_en[w_rb] = 1'b1; tmp_set = 1'b1; end
            S5: begin
              r_en[w_ra] = 1'b1;
              op         = ir[6:4];
              carry_in   = flag_c;
              acc_set    = 1'b1;
              flag_set   = 1'b1;
            end
            S6: begin
              // CMP only updates flags; the result is discarded.
              if (ir[6:4] != 3'b111) begin
                acc_en      = 1'b1;
                r_set[w_rb] = 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          case (ir[6:4])
            3'b000, 3'b001: begin
              if (r_step == S4) begin r_en[w_ra] = 1'b1; mar_set = 1'b1; end
              if (r_step == S5) begin
                if (ir[4]) begin r_en[w_rb] = 1'b1; ram_set = 1'b1; end
                else       begin ram_en = 1'b1; r_set[w_rb] = 1'b1; end
              end
            end
            3'b010: begin
              if (r_step == S4) begin iar_en = 1'b1; b1 = 1'b1; mar_set = 1'b1; acc_set = 1'b1; end
              if (r_step == S5) begin ram_en = 1'b1; r_set[w_rb] = 1'b1; end
              if (r_step == S6) begin acc_en = 1'b1; iar_set = 1'b1; end
            end
            3'b011: begin
              if (r_step == S4) begin r_en[w_rb] = 1'b1; iar_set = 1'b1; end
            end
            3'b100: begin
              if (r_step == S4) begin iar_en = 1'b1; mar_set = 1'b1; end
              if (r_step == S5) begin ram_en = 1'b1; iar_set = 1'b1; end
            end
            3'b101: begin
              // Not-taken path leaves IAR at the skip-over address from S5.
              if (r_step == S4) begin iar_en = 1'b1; b1 = 1'b1; mar_set = 1'b1; acc_set = 1'b1; end
              if (r_step == S5) begin acc_en = 1'b1; iar_set = 1'b1; end
              if (r_step == S6 && w_jump) begin ram_en = 1'b1; iar_set = 1'b1; end
            end
            3'b110: begin
              if (r_step == S4) begin b1 = 1'b1; flag_set = 1'b1; end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (!rst) begin
      r_en     = 4'b0000;
      r_set    = 4'b0000;
      iar_en   = 1'b0;
      iar_set  = 1'b0;
      ir_set   = 1'b0;
      mar_set  = 1'b0;
      ram_en   = 1'b0;
      ram_set  = 1'b0;
      tmp_set  = 1'b0;
      b1       = 1'b0;
      acc_en   = 1'b0;
      acc_set  = 1'b0;
      flag_set = 1'b0;
      op       = 3'b000;
      carry_in = 1'b0;
    end
  end

endmodule
